// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty levels, occupancy count and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     rd,
  input  logic                     err_clr,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_almost_full,
  output logic                     fifo_almost_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_overflow,
  output logic                     fifo_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              rd_acc;
  logic              wr_acc;

  // Handshake: wr/rd are requests sampled on every rising edge. A read is taken
  // whenever the FIFO holds data; a write is taken when there is room or when a
  // read in the same edge frees a slot. Rejected requests are dropped and only
  // leave a sticky overflow/underflow mark.
  assign rd_acc = rd && !fifo_empty;
  assign wr_acc = wr && (!fifo_full || rd_acc);

  assign fifo_full         = (fifo_count == CW'(DEPTH));
  assign fifo_empty        = (fifo_count == '0);
  assign fifo_almost_full  = (fifo_count >= CW'(AFULL_TH));
  assign fifo_almost_empty = (fifo_count <= CW'(AEMPTY_TH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr           <= '0;
      rptr           <= '0;
      fifo_count     <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      // A new error in the same cycle as err_clr keeps the flag set.
      if (wr && !wr_acc)  fifo_overflow <= 1'b1;
      else if (err_clr)   fifo_overflow <= 1'b0;
      if (rd && !rd_acc)  fifo_underflow <= 1'b1;
      else if (err_clr)   fifo_underflow <= 1'b0;
    end
  end

  // Storage is never cleared; reset only discards it by zeroing the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = fifo_empty ? '0 : mem[rptr];
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-mode 8-bit instance and an FWFT 32-bit
// instance share one stimulus stream and are checked against one queue model.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int AEMPTY = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] din = '0;

  logic [7:0]  dout_a;
  logic        full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a;
  logic [4:0]  cnt_a;
  logic [31:0] dout_b;
  logic        full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b;
  logic [4:0]  cnt_b;

  sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(0), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY)) u_std (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .err_clr(err_clr), .data_in(din[7:0]),
    .data_out(dout_a), .fifo_full(full_a), .fifo_empty(empty_a),
    .fifo_almost_full(afull_a), .fifo_almost_empty(aempty_a), .fifo_count(cnt_a),
    .fifo_overflow(ovf_a), .fifo_underflow(unf_a)
  );

  sync_fifo_param #(.DATA_W(32), .DEPTH(DEPTH), .FWFT(1), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY)) u_fwft (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .err_clr(err_clr), .data_in(din),
    .data_out(dout_b), .fifo_full(full_b), .fifo_empty(empty_b),
    .fifo_almost_full(afull_b), .fifo_almost_empty(aempty_b), .fifo_count(cnt_b),
    .fifo_overflow(ovf_b), .fifo_underflow(unf_b)
  );

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic [7:0]  m_dout_a = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("a_count",  32'(cnt_a),    32'(m_cnt));
    check("a_full",   32'(full_a),   32'(m_cnt == DEPTH));
    check("a_empty",  32'(empty_a),  32'(m_cnt == 0));
    check("a_afull",  32'(afull_a),  32'(m_cnt >= AFULL));
    check("a_aempty", 32'(aempty_a), 32'(m_cnt <= AEMPTY));
    check("a_ovf",    32'(ovf_a),    32'(m_ovf));
    check("a_unf",    32'(unf_a),    32'(m_unf));
    check("a_dout",   32'(dout_a),   32'(m_dout_a));
    check("b_count",  32'(cnt_b),    32'(m_cnt));
    check("b_full",   32'(full_b),   32'(m_cnt == DEPTH));
    check("b_empty",  32'(empty_b),  32'(m_cnt == 0));
    check("b_afull",  32'(afull_b),  32'(m_cnt >= AFULL));
    check("b_aempty", 32'(aempty_b), 32'(m_cnt <= AEMPTY));
    check("b_ovf",    32'(ovf_b),    32'(m_ovf));
    check("b_unf",    32'(unf_b),    32'(m_unf));
    if (exp_q.size() != 0) check("b_head", dout_b, exp_q[0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic w, input logic r, input logic clr, input logic [31:0] d);
    logic        r_acc;
    logic        w_acc;
    logic [31:0] t;
    wr = w; rd = r; err_clr = clr; din = d;
    r_acc = r && (m_cnt != 0);
    w_acc = w && ((m_cnt != DEPTH) || r_acc);
    @(posedge clk); #1;
    if (r_acc) begin
      t = exp_q.pop_front();
      m_dout_a = t[7:0];
    end
    if (w_acc) exp_q.push_back(d);
    m_cnt = m_cnt + (w_acc ? 1 : 0) - (r_acc ? 1 : 0);
    m_ovf = (w && !w_acc) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (r && !r_acc) ? 1'b1 : (clr ? 1'b0 : m_unf);
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input int ncyc, input logic w_during);
    rst = 1'b1; wr = w_during; din = 32'h99;
    repeat (ncyc) begin @(posedge clk); #1; end
    rst = 1'b0; wr = 1'b0;
    m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout_a = '0;
    exp_q.delete();
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    do_reset(2, 1'b0);
    check("rst_b_dout", dout_b, 32'h0);

    // fill, overflow, drain in order
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 1'b0, 32'(i));
    check("full_at_16", 32'(full_a), 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 32'h11);
    check("ovf_set", 32'(ovf_a), 32'h1);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("drain_order", 32'(dout_a), 32'(i));
    end

    // underflow, clear, clear+error together
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("unf_hold_dout", 32'(dout_a), 32'h10);
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    check("unf_cleared", 32'(unf_a), 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0);
    check("unf_set_wins", 32'(unf_a), 32'h1);
    cycle(1'b0, 1'b0, 1'b1, 32'h0);

    // full with simultaneous wr+rd across pointer wrap
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 32'h20 + 32'(i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 32'h40 + 32'(i));
    check("wrap_no_ovf", 32'(ovf_a), 32'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // fall-through head word, then wr+rd while empty
    cycle(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    check("fwft_head", dout_b, 32'hDEADBEEF);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("fwft_empty", 32'(empty_b), 32'h1);
    cycle(1'b1, 1'b1, 1'b0, 32'hCAFE0001);
    check("empty_wr_rd_cnt", 32'(cnt_b), 32'h1);
    check("empty_wr_rd_unf", 32'(unf_b), 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 32'h0);

    // reset mid-operation with wr held high
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h60 + 32'(i));
    do_reset(1, 1'b1);
    check("mid_rst_cnt", 32'(cnt_a), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'hA0 + 32'(i));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("post_rst_data", 32'(dout_a), 32'hA0 + 32'(i));
    end

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), $urandom);
    while (m_cnt != 0) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
